// File: rtl/trig_seq_pkg.sv
// Shared definitions for the delayed trigger sequencer.
package trig_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LEARN     = 3'd1,
    ST_ARM       = 3'd2,
    ST_WAIT_TRIG = 3'd3,
    ST_RUN       = 3'd4,
    ST_RELEASE   = 3'd5
  } seq_state_t;

endpackage

// File: rtl/period_averager.sv
// Rolling average of the last 2**L captured frame periods.
module period_averager #(
  parameter int W = 32,
  parameter int L = 3
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         clear,
  input  logic         sample_valid,
  input  logic [W-1:0] sample,
  output logic [W-1:0] average,
  output logic         avg_valid
);

  localparam int unsigned DEPTH = 2 ** L;
  localparam logic [L:0]  FULL  = (L + 1)'(DEPTH);

  logic [W-1:0]   hist [DEPTH];
  logic [L-1:0]   wr_ptr;
  logic [L:0]     fill;
  logic [W+L-1:0] sum;
  logic [W+L-1:0] sum_next;

  // Replace the oldest entry's contribution with the new sample.
  always_comb begin
    sum_next = sum + {{L{1'b0}}, sample} - {{L{1'b0}}, hist[wr_ptr]};
  end

  // History buffer, running sum and registered average; clear keeps the last average.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      hist      <= '{default: '0};
      wr_ptr    <= '0;
      fill      <= '0;
      sum       <= '0;
      average   <= '0;
      avg_valid <= 1'b0;
    end else if (clear) begin
      hist      <= '{default: '0};
      wr_ptr    <= '0;
      fill      <= '0;
      sum       <= '0;
      avg_valid <= 1'b0;
    end else if (sample_valid) begin
      hist[wr_ptr] <= sample;
      wr_ptr       <= wr_ptr + 1'b1;
      sum          <= sum_next;
      average      <= sum_next[W+L-1:L];
      if (fill != FULL) fill <= fill + 1'b1;
      if (fill == FULL - 1'b1) avg_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/delayed_trigger_sequencer.sv
// Learns the frame period, arms the trigger block, holds it for a burst, releases it.
module delayed_trigger_sequencer
  import trig_seq_pkg::*;
#(
  parameter int COUNTER_WIDTH = 32,
  parameter int AVG_LOG2      = 3,
  parameter int BURST_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic                     start,
  input  logic                     stop,
  input  logic [BURST_WIDTH-1:0]   burst_periods,
  input  logic [COUNTER_WIDTH-1:0] tolerance,
  input  logic                     period_event,
  input  logic [COUNTER_WIDTH-1:0] last_counter,
  input  logic                     trigger,
  input  logic                     trigger_armed,
  output logic                     trigger_arm,
  output logic                     trigger_reset,
  output logic [COUNTER_WIDTH-1:0] reference_counter,
  output logic                     avg_valid,
  output logic [BURST_WIDTH-1:0]   periods_done,
  output logic [2:0]               state,
  output logic                     busy,
  output logic                     period_error
);

  seq_state_t cur_state, next_state;

  logic                     period_event_q;
  logic                     ev;
  logic                     ev_q;
  logic                     capture;
  logic                     discard;
  logic                     sample_valid;
  logic                     start_accept;
  logic                     check_state;
  logic                     tol_violation;
  logic [COUNTER_WIDTH-1:0] abs_diff;
  logic [BURST_WIDTH:0]     done_plus1;

  assign ev           = period_event & ~period_event_q;
  // last_counter is valid the cycle after the frame edge; IDLE ignores captures.
  assign capture      = ev_q & (cur_state != ST_IDLE);
  assign sample_valid = capture & ~discard;
  assign done_plus1   = {1'b0, periods_done} + 1'b1;
  assign state        = cur_state;
  assign busy         = (cur_state != ST_IDLE);

  // Tolerance check against the average in force before this sample is absorbed.
  always_comb begin
    abs_diff      = (last_counter >= reference_counter) ? (last_counter - reference_counter)
                                                        : (reference_counter - last_counter);
    check_state   = (cur_state == ST_ARM) || (cur_state == ST_WAIT_TRIG) || (cur_state == ST_RUN);
    tol_violation = sample_valid & check_state & (tolerance != '0) & (abs_diff > tolerance);
  end

  // Next-state and Moore outputs; stop or a tolerance hit overrides any busy-state exit.
  always_comb begin
    next_state    = cur_state;
    trigger_arm   = 1'b0;
    trigger_reset = 1'b0;
    start_accept  = 1'b0;
    case (cur_state)
      ST_IDLE: begin
        if (start && !stop) begin
          next_state   = ST_LEARN;
          start_accept = 1'b1;
        end
      end
      ST_LEARN:     if (avg_valid) next_state = ST_ARM;
      ST_ARM: begin
        trigger_arm = 1'b1;
        next_state  = ST_WAIT_TRIG;
      end
      ST_WAIT_TRIG: if (trigger) next_state = ST_RUN;
      ST_RUN: begin
        if (ev && (burst_periods != '0) && (done_plus1 == {1'b0, burst_periods}))
          next_state = ST_RELEASE;
      end
      ST_RELEASE: begin
        trigger_reset = 1'b1;
        if (!trigger && !trigger_armed) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
    if ((cur_state != ST_IDLE) && (stop || tol_violation)) next_state = ST_RELEASE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!aresetn) cur_state <= ST_IDLE;
    else          cur_state <= next_state;
  end

  // Frame edge detection and capture-cycle alignment.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      period_event_q <= 1'b0;
      ev_q           <= 1'b0;
    end else begin
      period_event_q <= period_event;
      ev_q           <= ev;
    end
  end

  // Sequence status: partial-period discard, burst count, sticky tolerance error.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      discard      <= 1'b0;
      periods_done <= '0;
      period_error <= 1'b0;
    end else if (start_accept) begin
      discard      <= 1'b1;
      periods_done <= '0;
      period_error <= 1'b0;
    end else begin
      if (capture) discard <= 1'b0;
      if ((cur_state == ST_RUN) && ev && (periods_done != '1))
        periods_done <= periods_done + 1'b1;
      if (tol_violation) period_error <= 1'b1;
    end
  end

  period_averager #(
    .W(COUNTER_WIDTH),
    .L(AVG_LOG2)
  ) u_avg (
    .clk          (clk),
    .aresetn      (aresetn),
    .clear        (start_accept),
    .sample_valid (sample_valid),
    .sample       (last_counter),
    .average      (reference_counter),
    .avg_valid    (avg_valid)
  );

endmodule

// File: tb/tb_delayed_trigger_sequencer.sv
// Bench for delayed_trigger_sequencer: directed scenarios plus randomized sequences.
module tb_delayed_trigger_sequencer;

  localparam int CW = 32;
  localparam int AL = 3;
  localparam int BW = 16;
  localparam int N  = 2 ** AL;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [BW-1:0] burst_periods = '0;
  logic [CW-1:0] tolerance = '0;
  logic          period_event = 1'b0;
  logic [CW-1:0] last_counter = '0;
  logic          trigger = 1'b0;
  logic          trigger_armed = 1'b0;
  logic          trigger_arm;
  logic          trigger_reset;
  logic [CW-1:0] reference_counter;
  logic          avg_valid;
  logic [BW-1:0] periods_done;
  logic [2:0]    state;
  logic          busy;
  logic          period_error;

  delayed_trigger_sequencer #(
    .COUNTER_WIDTH(CW),
    .AVG_LOG2(AL),
    .BURST_WIDTH(BW)
  ) dut (
    .clk(clk), .aresetn(aresetn), .start(start), .stop(stop),
    .burst_periods(burst_periods), .tolerance(tolerance),
    .period_event(period_event), .last_counter(last_counter),
    .trigger(trigger), .trigger_armed(trigger_armed),
    .trigger_arm(trigger_arm), .trigger_reset(trigger_reset),
    .reference_counter(reference_counter), .avg_valid(avg_valid),
    .periods_done(periods_done), .state(state), .busy(busy),
    .period_error(period_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input int code, input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (state == 3'(code)) break;
    end
    n_checks++;
    if (i == budget) begin
      n_fail++;
      $display("FAIL %s: state %0d not reached within %0d cycles (state=%0d)", name, code, budget, state);
    end
  endtask

  // ---------------- frame source (stands in for the trigger block counter) ------------
  bit gen_en  = 1'b0;
  int base    = 1000;
  int jit     = 0;
  int gap_jit = 0;
  int rise_cnt = 0;

  initial begin
    forever begin
      if (gen_en) begin
        int gap;
        gap = 6 + $urandom_range(0, gap_jit);
        period_event = 1'b1;
        last_counter = CW'(base + $urandom_range(0, jit));
        rise_cnt++;
        tick();
        tick();
        period_event = 1'b0;
        repeat (gap - 2) tick();
      end else begin
        tick();
      end
    end
  end

  // ---------------- trigger block behaviour -------------------------------------------
  int fire_delay = 3;
  int rel_delay  = 2;

  initial begin
    bit a, r, rs;
    int fire_cnt, rel_cnt;
    fire_cnt = 0;
    rel_cnt  = 0;
    forever begin
      @(negedge clk);
      a  = trigger_arm;
      r  = trigger_reset;
      rs = aresetn;
      tick();
      if (!rs) begin
        trigger = 1'b0; trigger_armed = 1'b0; fire_cnt = 0; rel_cnt = 0;
      end else begin
        if (r) begin
          rel_cnt++;
          if (rel_cnt >= rel_delay) begin trigger = 1'b0; trigger_armed = 1'b0; end
        end else begin
          rel_cnt = 0;
        end
        if (a) begin
          trigger_armed = 1'b1;
          fire_cnt = fire_delay;
        end else if (trigger_armed && !trigger && !r) begin
          if (fire_cnt > 0) fire_cnt--;
          else trigger = 1'b1;
        end
      end
    end
  end

  // ---------------- behavioural reference ---------------------------------------------
  // State codes: 0 idle, 1 learn, 2 arm, 3 wait, 4 run, 5 release.
  int      m_st = 0;
  int      m_pd = 0;
  bit      m_err = 1'b0, m_av = 1'b0, m_disc = 1'b0, m_peq = 1'b0, m_evq = 1'b0;
  bit      m_live = 1'b0;
  longint  m_ref = 0;
  longint  q[$];

  always @(posedge clk) begin
    bit ev, cap, acc, viol, av_old;
    longint s, d, sum;
    int nst;
    if (!aresetn) begin
      m_st = 0; m_pd = 0; m_err = 0; m_av = 0; m_disc = 0; m_peq = 0; m_evq = 0;
      m_ref = 0; q.delete();
    end else begin
      ev     = period_event && !m_peq;
      cap    = m_evq && (m_st != 0);
      acc    = (m_st == 0) && start && !stop;
      viol   = 1'b0;
      av_old = m_av;
      if (cap) begin
        if (m_disc) begin
          m_disc = 1'b0;
        end else begin
          s = longint'(last_counter);
          d = s - m_ref;
          if (d < 0) d = -d;
          if ((m_st >= 2) && (m_st <= 4) && (tolerance != 0) && (d > longint'(tolerance))) viol = 1'b1;
          q.push_back(s);
          if (q.size() > N) void'(q.pop_front());
          sum = 0;
          foreach (q[i]) sum += q[i];
          m_ref = sum / N;
          if (q.size() == N) m_av = 1'b1;
        end
      end
      nst = m_st;
      case (m_st)
        0: if (acc) nst = 1;
        1: if (av_old) nst = 2;
        2: nst = 3;
        3: if (trigger) nst = 4;
        4: if (ev && (burst_periods != 0) && (m_pd + 1 == int'(burst_periods))) nst = 5;
        5: if (!trigger && !trigger_armed) nst = 0;
        default: nst = 0;
      endcase
      if ((m_st != 0) && (stop || viol)) nst = 5;
      if (viol) m_err = 1'b1;
      if ((m_st == 4) && ev && (m_pd < (2 ** BW) - 1)) m_pd++;
      if (acc) begin
        q.delete(); m_av = 0; m_disc = 1; m_pd = 0; m_err = 0;
      end
      m_peq = period_event;
      m_evq = ev;
      m_st  = nst;
    end
    m_live = 1'b1;
  end

  // Cycle-by-cycle comparison against the reference.
  always @(negedge clk) begin
    if (m_live) begin
      chk("state",         state,             m_st);
      chk("busy",          busy,              (m_st != 0));
      chk("trigger_arm",   trigger_arm,       (m_st == 2));
      chk("trigger_reset", trigger_reset,     (m_st == 5));
      chk("reference",     reference_counter, m_ref);
      chk("avg_valid",     avg_valid,         m_av);
      chk("periods_done",  periods_done,      m_pd);
      chk("period_error",  period_error,      m_err);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ---------------------------------------------------------
  initial begin
    repeat (3) tick();
    aresetn = 1'b1;
    @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_ref", reference_counter, 0);
    chk("rst_avg_valid", avg_valid, 0);
    chk("rst_periods_done", periods_done, 0);
    tick();

    // Learn 1000-count periods, then a 4-period burst.
    base = 1000; jit = 0; burst_periods = 16'd4; tolerance = '0;
    rise_cnt = 0;
    start = 1'b1; tick(); start = 1'b0;
    gen_en = 1'b1;
    wait_state(2, 300, "learn_to_arm");
    chk("arm_ref", reference_counter, 1000);
    chk("arm_avg_valid", avg_valid, 1);
    chk("arm_rises", rise_cnt, 9);
    chk("arm_pulse", trigger_arm, 1);
    @(negedge clk);
    chk("arm_pulse_end", trigger_arm, 0);
    wait_state(4, 50, "enter_run");
    wait_state(5, 200, "burst_release");
    chk("burst_count", periods_done, 4);
    chk("release_reset", trigger_reset, 1);
    wait_state(0, 50, "burst_idle");
    chk("idle_trigger", trigger, 0);
    chk("idle_armed", trigger_armed, 0);
    chk("idle_count_held", periods_done, 4);

    // Open-ended burst, ignored start while running, then stop after 20 periods.
    burst_periods = '0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_state(4, 400, "open_run");
    tick(); start = 1'b1; tick(); start = 1'b0;
    @(negedge clk);
    chk("start_in_run", state, 4);
    begin
      int k;
      for (k = 0; k < 400; k++) begin
        @(negedge clk);
        if (periods_done == 16'd20) break;
      end
      chk("reach_20", (k < 400), 1);
    end
    tick(); stop = 1'b1; tick(); stop = 1'b0;
    @(negedge clk);
    chk("stop_release", state, 5);
    chk("stop_count", periods_done, 20);
    wait_state(0, 50, "stop_idle");

    // Tolerance violation during the burst; next start clears the flag.
    tolerance = 32'd5;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_state(4, 400, "tol_run");
    base = 1010;
    begin
      int k;
      for (k = 0; k < 100; k++) begin
        @(negedge clk);
        if (period_error) break;
      end
      chk("tol_error", period_error, 1);
      chk("tol_release", state, 5);
    end
    wait_state(0, 50, "tol_idle");
    chk("tol_sticky", period_error, 1);
    base = 1000; tolerance = '0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    @(negedge clk);
    chk("tol_cleared", period_error, 0);
    tick(); stop = 1'b1; tick(); stop = 1'b0;
    wait_state(0, 50, "abort_learn");

    // Simultaneous start and stop while idle.
    tick();
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    @(negedge clk);
    chk("start_stop_idle", state, 0);
    chk("start_stop_busy", busy, 0);

    // Reset in the middle of a burst.
    tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_state(4, 400, "reset_run");
    tick();
    aresetn = 1'b0; tick();
    @(negedge clk);
    chk("mid_reset_state", state, 0);
    chk("mid_reset_ref", reference_counter, 0);
    chk("mid_reset_done", periods_done, 0);
    chk("mid_reset_trigger_reset", trigger_reset, 0);
    aresetn = 1'b1;
    tick();

    // Randomized sequences.
    for (int it = 0; it < 6; it++) begin
      base    = 500 + $urandom_range(0, 99);
      jit     = $urandom_range(0, 8);
      gap_jit = $urandom_range(0, 4);
      tolerance     = ($urandom_range(0, 1) == 1) ? CW'($urandom_range(3, 10)) : '0;
      burst_periods = BW'($urandom_range(0, 5));
      tick();
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < 400; k++) begin
        stop  = ($urandom_range(0, 249) == 0) || (k == 399);
        start = ($urandom_range(0, 99) == 0);
        tick();
        stop = 1'b0; start = 1'b0;
        if (state == 3'd0) break;
      end
      wait_state(0, 60, "rand_idle");
    end

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
